// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: byte output handshake and status pulses of the UART receiver.
// master = receiver side, slave = byte consumer side.
interface uart_rx_fsm_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output framing_err,
        output overrun,
        output parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  framing_err,
        input  overrun,
        input  parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control, 8N1 (8E1 with UART_RX_PARITY_EN defined).
// Uses an external down-counter's CO pulse as the half-bit / full-bit timebase.
module uart_rx_fsm #(
    parameter logic [7:0] BIT_LOAD  = 8'd215,
    parameter logic [7:0] HALF_LOAD = 8'd106
) (
    input  logic          CLOCK,
    input  logic          reset_n,
    input  logic          rx,
    input  logic          cntr_co,
    output logic          cntr_load,
    output logic [7:0]    cntr_load_value,
    uart_rx_fsm_if.master bus
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;
`endif

    state_t     state, state_nxt;
    logic       rx_meta, rx_s;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_idx, idx_nxt;
    logic       load_nxt;
    logic [7:0] lval_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       fe_nxt, ov_nxt;
    logic       good_byte;

`ifdef UART_RX_PARITY_EN
    logic       par_bad, par_bad_nxt, pe_nxt, pe_q;
`endif

    // Two-flop synchroniser; idle-high line so both flops reset to 1.
    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Next-state and registered-output decisions for the frame sequencer.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = bit_idx;
        load_nxt  = 1'b0;
        lval_nxt  = cntr_load_value;
        data_nxt  = bus.rx_data;
        valid_nxt = bus.rx_valid;
        fe_nxt    = 1'b0;
        ov_nxt    = 1'b0;
        good_byte = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        pe_nxt      = 1'b0;
`endif
        // A consumer handshake frees the output register.
        if (bus.rx_valid && bus.rx_ready) begin
            valid_nxt = 1'b0;
        end
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    load_nxt  = 1'b1;
                    lval_nxt  = HALF_LOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (cntr_co) begin
                    if (!rx_s) begin
                        load_nxt  = 1'b1;
                        lval_nxt  = BIT_LOAD;
                        idx_nxt   = 3'd0;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cntr_co) begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    load_nxt  = 1'b1;
                    lval_nxt  = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cntr_co) begin
                    // Even parity: odd count of ones over data+parity is bad.
                    par_bad_nxt = ^{shreg, rx_s};
                    load_nxt    = 1'b1;
                    lval_nxt    = BIT_LOAD;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (cntr_co) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                        good_byte = 1'b1;
                    end else begin
                        fe_nxt    = 1'b1;
                        state_nxt = BREAK;
                    end
`ifdef UART_RX_PARITY_EN
                    pe_nxt = par_bad;
                    if (par_bad) begin
                        good_byte = 1'b0;
                    end
`endif
                    if (good_byte) begin
                        if (bus.rx_valid && !bus.rx_ready) begin
                            ov_nxt = 1'b1;
                        end else begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                        end
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus all registered outputs.
    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            shreg           <= 8'd0;
            bit_idx         <= 3'd0;
            cntr_load       <= 1'b0;
            cntr_load_value <= 8'd0;
            bus.rx_data     <= 8'd0;
            bus.rx_valid    <= 1'b0;
            bus.framing_err <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            state           <= state_nxt;
            shreg           <= shreg_nxt;
            bit_idx         <= idx_nxt;
            cntr_load       <= load_nxt;
            cntr_load_value <= lval_nxt;
            bus.rx_data     <= data_nxt;
            bus.rx_valid    <= valid_nxt;
            bus.framing_err <= fe_nxt;
            bus.overrun     <= ov_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict held from PARITY to the STOP decision, plus its pulse.
    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            par_bad <= par_bad_nxt;
            pe_q    <= pe_nxt;
        end
    end

    assign bus.parity_err = pe_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
